// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the multiplier and the planned adder.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: operand class enum, exception flag struct, bias/width helpers,
// and the canonical quiet-NaN pattern builder.
package fp_pkg;

    typedef enum logic [1:0] {
        ZERO,
        NORM,
        INF,
        NAN
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // Widest format the NaN builder can describe; callers slice it down.
    localparam int FP_MAX_W = 64;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_float_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    // Sign 0, exponent all ones, mantissa MSB set, all other bits clear.
    function automatic logic [FP_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even and pack a finite nonzero product.
// Latency: combinational.
// Backpressure: none; the enclosing stage register decides when to sample.
// Ports: sign, exp_sum (signed unbiased-sum exponent, EXP_W+2 bits),
// prod (raw 1.x * 1.x mantissa product) -> res (packed float), flags.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    parameter int FLOAT_W = fp_float_w(EXP_W, MAN_W)
) (
    input  logic                      sign,
    input  logic signed [EXP_W+1:0]   exp_sum,
    input  logic        [2*MAN_W+1:0] prod,
    output logic        [FLOAT_W-1:0] res,
    output fp_flags_t                 flags
);

    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] EXP_ONE  = (EXP_W + 2)'(1);
    localparam logic signed [EXP_W+1:0] EXP_ZERO = (EXP_W + 2)'(0);
    localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W + 2)'(fp_exp_max(EXP_W));

    // norm drops the leading one, so its top MAN_W bits are the kept mantissa.
    logic        [PW-2:0]    norm;
    logic signed [EXP_W+1:0] exp_norm;
    logic signed [EXP_W+1:0] exp_rnd;
    logic        [MAN_W-1:0] man;
    logic        [MAN_W:0]   man_rnd;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic                    ovf;
    logic                    unf;

    always_comb begin
        norm     = '0;
        exp_norm = exp_sum;
        if (prod[PW-1]) begin
            // Product in [2,4): mantissa sits below the MSB, one more binade.
            norm     = prod[PW-2:0];
            exp_norm = exp_sum + EXP_ONE;
        end else begin
            norm = {prod[PW-3:0], 1'b0};
        end

        man      = norm[PW-2 -: MAN_W];
        guard    = norm[MAN_W];
        sticky   = |norm[MAN_W-1:0];
        round_up = guard & (sticky | man[0]);

        // A carry out leaves the low MAN_W bits at zero, which is exactly 1.0.
        man_rnd  = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
        exp_rnd  = man_rnd[MAN_W] ? exp_norm + EXP_ONE : exp_norm;

        ovf      = (exp_rnd >= EXP_MAX);
        unf      = (exp_rnd <= EXP_ZERO);

        if (ovf) begin
            res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            res = {sign, {(FLOAT_W-1){1'b0}}};
        end else begin
            res = {sign, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
        end

        flags.invalid   = 1'b0;
        flags.overflow  = ovf;
        flags.underflow = unf;
        flags.inexact   = guard | sticky | ovf | unf;
    end

endmodule

// File: rtl/float_multiple_pipe.sv
// Pipelined IEEE-754-style multiplier with RNE rounding and special values.
// Latency: 3 cycles accept-to-out_valid; one product per cycle when unstalled.
// Backpressure: whole pipe holds while out_valid & ~out_ready; in_ready = ~stall.
// Ports: clk, rst_n (sync, active low), in_valid/in_ready + float_a/float_b,
// out_valid/out_ready + res; res_flags {invalid,overflow,underflow,inexact}
// exists only when FMUL_FLAGS_EN is defined.
module float_multiple_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W   = 5,
    parameter int MAN_W   = 10,
    // Derived from the two field widths; leave at its default.
    parameter int FLOAT_W = fp_float_w(EXP_W, MAN_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLOAT_W-1:0] float_a,
    input  logic [FLOAT_W-1:0] float_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLOAT_W-1:0] res
`ifdef FMUL_FLAGS_EN
    ,
    output logic [3:0]         res_flags
`endif
);

    localparam int EW2 = EXP_W + 2;
    localparam int MW1 = MAN_W + 1;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic [FP_MAX_W-1:0]  NAN_WIDE = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [FLOAT_W-1:0]   NAN_VAL  = NAN_WIDE[FLOAT_W-1:0];
    localparam logic signed [EW2-1:0] BIAS_S  = EW2'(fp_bias(EXP_W));

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] m);
        if (e == '0) begin
            return ZERO;           // subnormals flush to zero here
        end
        if (&e) begin
            return (m == '0) ? INF : NAN;
        end
        return NORM;
    endfunction

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: unpack, classify, sign, exponent sum -------------
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [MAN_W-1:0]   man_a, man_b;
    fp_class_t          cls_a, cls_b;
    logic               c1_sign;
    logic               c1_nan;
    logic               c1_spec;
    logic [FLOAT_W-1:0] c1_spec_res;
    logic signed [EW2-1:0] c1_exp;

    assign exp_a   = float_a[FLOAT_W-2 -: EXP_W];
    assign exp_b   = float_b[FLOAT_W-2 -: EXP_W];
    assign man_a   = float_a[MAN_W-1:0];
    assign man_b   = float_b[MAN_W-1:0];
    assign cls_a   = classify(exp_a, man_a);
    assign cls_b   = classify(exp_b, man_b);
    assign c1_sign = float_a[FLOAT_W-1] ^ float_b[FLOAT_W-1];
    assign c1_exp  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;

    always_comb begin
        c1_nan      = (cls_a == NAN) || (cls_b == NAN)
                   || (cls_a == INF && cls_b == ZERO)
                   || (cls_a == ZERO && cls_b == INF);
        c1_spec     = 1'b1;
        c1_spec_res = '0;
        if (c1_nan) begin
            c1_spec_res = NAN_VAL;
        end else if (cls_a == INF || cls_b == INF) begin
            c1_spec_res = {c1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            c1_spec_res = {c1_sign, {(FLOAT_W-1){1'b0}}};
        end else begin
            c1_spec     = 1'b0;
        end
    end

    logic                  s1_vld, s2_vld;
    logic                  s1_sign, s2_sign;
    logic signed [EW2-1:0] s1_exp, s2_exp;
    logic [MW1-1:0]        s1_ma, s1_mb;
    logic                  s1_spec, s2_spec;
    logic [FLOAT_W-1:0]    s1_spec_res, s2_spec_res;
    logic [PW-1:0]         s2_prod;

    // ---------------- S3: normalise / round / pack -------------------------
    logic [FLOAT_W-1:0] rp_res;
`ifdef FMUL_FLAGS_EN
    fp_flags_t rp_flags;
    fp_flags_t spec_flags;
    logic      s1_invalid, s2_invalid;
`else
    fp_flags_t unused_rp_flags;
`endif

    fp_round_pack #(
        .EXP_W   (EXP_W),
        .MAN_W   (MAN_W),
        .FLOAT_W (FLOAT_W)
    ) u_round_pack (
        .sign    (s2_sign),
        .exp_sum (s2_exp),
        .prod    (s2_prod),
        .res     (rp_res),
`ifdef FMUL_FLAGS_EN
        .flags   (rp_flags)
`else
        .flags   (unused_rp_flags)
`endif
    );

`ifdef FMUL_FLAGS_EN
    always_comb begin
        spec_flags           = '0;
        spec_flags.invalid   = s2_invalid;
    end
`endif

    // Stage valids and the output register: these carry the reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            res       <= '0;
`ifdef FMUL_FLAGS_EN
            res_flags <= '0;
`endif
        end else if (!stall) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            // Bubbles leave the last result on res rather than garbage.
            if (s2_vld) begin
                res       <= s2_spec ? s2_spec_res : rp_res;
`ifdef FMUL_FLAGS_EN
                res_flags <= s2_spec ? spec_flags : rp_flags;
`endif
            end
        end
    end

    // Datapath registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sign     <= c1_sign;
            s1_exp      <= c1_exp;
            s1_ma       <= {1'b1, man_a};
            s1_mb       <= {1'b1, man_b};
            s1_spec     <= c1_spec;
            s1_spec_res <= c1_spec_res;

            s2_sign     <= s1_sign;
            s2_exp      <= s1_exp;
            s2_prod     <= PW'(s1_ma) * PW'(s1_mb);
            s2_spec     <= s1_spec;
            s2_spec_res <= s1_spec_res;
`ifdef FMUL_FLAGS_EN
            s1_invalid  <= c1_nan;
            s2_invalid  <= s1_invalid;
`endif
        end
    end

endmodule

// File: tb/tb_float_multiple_pipe.sv
// Self-checking bench for float_multiple_pipe (fp16 default parameters).
// Latency: n/a.
// Backpressure: exercised with directed and random out_ready patterns.
module tb_float_multiple_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float_a;
    logic [15:0] float_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
`ifdef FMUL_FLAGS_EN
    logic [3:0]  res_flags;
`endif

    always #5 clk = ~clk;

    float_multiple_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .float_a   (float_a),
        .float_b   (float_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
`ifdef FMUL_FLAGS_EN
        ,
        .res_flags (res_flags)
`endif
    );

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ret_cnt = 0;
    logic [15:0] cur_r;
    logic [3:0]  cur_f;
    bit          cur_lat;
    bit          last_acc;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the remainder
    // against half an ulp; flags {invalid, overflow, underflow, inexact}.
    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] f);
        int     ea, eb, ma, mb, sh, e;
        bit     s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint p, q, rem, half;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        ma = int'(a[9:0]);   mb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        a_nan  = (ea == 31) && (ma != 0);  b_nan  = (eb == 31) && (mb != 0);
        a_inf  = (ea == 31) && (ma == 0);  b_inf  = (eb == 31) && (mb == 0);
        a_zero = (ea == 0);                b_zero = (eb == 0);
        f = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            r = 16'h7E00; f = 4'b1000; return;
        end
        if (a_inf || b_inf) begin r = {s, 15'h7C00}; return; end
        if (a_zero || b_zero) begin r = {s, 15'h0000}; return; end
        p    = longint'(1024 + ma) * longint'(1024 + mb);
        sh   = (p >= (64'sd1 << 21)) ? 11 : 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'sd1 << (sh - 1);
        e    = ea + eb - 15 + (sh - 10);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        if (q == 2048) begin q = 1024; e = e + 1; end
        if (e >= 31) begin
            r = {s, 15'h7C00}; f = 4'b0101;
        end else if (e <= 0) begin
            r = {s, 15'h0000}; f = 4'b0011;
        end else begin
            r = {s, 5'(e), 10'(q)}; f = {3'b000, rem != 0};
        end
    endfunction

    function automatic logic [15:0] rnd_fp();
        logic [4:0] e;
        logic [9:0] m;
        int         k;
        k = $urandom_range(0, 9);
        m = 10'($urandom);
        case (k)
            0:       e = 5'd0;
            1:       begin e = 5'd31; if ($urandom_range(0, 1) == 0) m = '0; end
            2:       e = 5'($urandom_range(1, 4));
            3:       e = 5'($urandom_range(26, 30));
            default: e = 5'($urandom_range(9, 21));
        endcase
        return {1'($urandom), e, m};
    endfunction

    // One clock: observe at the falling edge, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        last_acc = 1'b0;
        if (!rst_n) begin
            sbq.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                chk("stall_vld", out_valid, 1);
                chk("stall_res", res, prev_res);
            end
            if (out_valid && out_ready) begin
                ret_cnt++;
                if (sbq.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res", res, e.r);
`ifdef FMUL_FLAGS_EN
                    chk("flags", res_flags, e.f);
`endif
                    if (e.lat) chk("latency", cyc - e.cyc, 3);
                end
            end
            if (in_valid && in_ready) begin
                sbq.push_back('{r: cur_r, f: cur_f, cyc: cyc, lat: cur_lat});
                last_acc = 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = res;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] r, input logic [3:0] f, input bit lat);
        float_a = a; float_b = b; cur_r = r; cur_f = f; cur_lat = lat;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", in_ready, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (sbq.size() == 0) break;
            tick();
        end
        chk("drain_empty", sbq.size(), 0);
        tick();
    endtask

    logic [15:0] da [10] = '{16'h3C00, 16'h4000, 16'h7BFF, 16'h0400, 16'h8400,
                             16'h7C00, 16'h7E01, 16'hFC00, 16'h3C01, 16'h3FFF};
    logic [15:0] db [10] = '{16'h3C00, 16'hC200, 16'h4000, 16'h0400, 16'h0400,
                             16'h0000, 16'h3C00, 16'h4000, 16'h3C01, 16'h3FFF};
    logic [15:0] dr [10] = '{16'h3C00, 16'hC600, 16'h7C00, 16'h0000, 16'h8000,
                             16'h7E00, 16'h7E00, 16'hFC00, 16'h3C02, 16'h43FE};
    logic [3:0]  df [10] = '{4'b0000, 4'b0000, 4'b0101, 4'b0011, 4'b0011,
                             4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001};
    logic [15:0] bpa [5];
    logic [15:0] bpb [5];

    initial begin
        int idx;
        logic [15:0] mr;
        logic [3:0]  mf;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        float_a = '0; float_b = '0; cur_r = '0; cur_f = '0; cur_lat = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_res", res, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef FMUL_FLAGS_EN
        chk("rst_flags", res_flags, 0);
`endif

        // Directed vectors, back to back with a free-running consumer.
        for (int i = 0; i < 10; i++) send(da[i], db[i], dr[i], df[i], 1'b1);
        drain();

        // Backpressure: consumer blocked while five operands are offered.
        for (int i = 0; i < 5; i++) begin
            bpa[i] = rnd_fp(); bpb[i] = rnd_fp();
        end
        out_ready = 1'b0;
        ret_cnt   = 0;
        idx       = 0;
        for (int k = 0; k < 8; k++) begin
            float_a = bpa[idx]; float_b = bpb[idx];
            ref_mul(bpa[idx], bpb[idx], cur_r, cur_f);
            cur_lat  = 1'b0;
            in_valid = 1'b1;
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int i = idx; i < 5; i++) begin
            ref_mul(bpa[i], bpb[i], mr, mf);
            send(bpa[i], bpb[i], mr, mf, 1'b0);
        end
        drain();
        chk("bp_returned", ret_cnt, 5);

        // Random traffic with random stalls.
        for (int k = 0; k < 400; k++) begin
            float_a   = rnd_fp();
            float_b   = rnd_fp();
            ref_mul(float_a, float_b, cur_r, cur_f);
            cur_lat   = 1'b0;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset with two operations in flight.
        ref_mul(16'h4200, 16'h4200, mr, mf);
        send(16'h4200, 16'h4200, mr, mf, 1'b0);
        send(16'h3C00, 16'hC000, 16'hC000, 4'b0000, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_res", res, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_mid_quiet", out_valid, 0);
        end
        chk("rst_mid_res_end", res, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
